single_port_mem_master: RTL and testbench
=========================================

// Module: single_port_mem_master
// PURPOSE
//  Initiator side of the 32x32 single-port memory interface: accepts burst commands over valid/ready,
//  drives mem_mode/mem_addr/mem_data_in, and returns read data as a stream. Sits between datapath
//  clients and the single_port_memory instance; owns all mode/address sequencing for that memory.
// PARAMETERS
//  ADDR_W      5   memory address width (depth = 2**ADDR_W)
//  DATA_W      32  memory data width
//  RD_LATENCY  1   cycles from read address presented (mem_mode=1) to valid mem_data_out, 1..4
// PORTS
//  clk          in   1       single clock, all state on posedge
//  rst          in   1       asynchronous, active-high reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1       1 = write burst, 0 = read burst
//  cmd_addr     in   ADDR_W  start address
//  cmd_len      in   ADDR_W  beats minus one (0 => 1 beat, 31 => 32 beats)
//  wdata_valid  in   1       write beat offered
//  wdata_ready  out  1       write beat consumed when wdata_valid & wdata_ready
//  wdata        in   DATA_W  write beat data
//  rdata_valid  out  1       read beat valid (no backpressure; sink always accepts)
//  rdata        out  DATA_W  read beat data
//  busy         out  1       burst in progress or read data still in flight
//  err          out  1       one-cycle pulse on rejected command (MEM_MASTER_BOUND_CHECK_EN only)
//  mem_mode     out  1       to memory: 0 = write, 1 = read
//  mem_addr     out  ADDR_W  to memory address
//  mem_data_in  out  DATA_W  to memory write data
//  mem_data_out in   DATA_W  from memory read data
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1, wdata_ready=0, rdata_valid=0, rdata=0, busy=0, err=0,
//    mem_mode=1 (read: never writes while idle), mem_addr=0, mem_data_in=0.
//  - FSM IDLE -> WRITE | READ on accept; READ -> DRAIN after last address; WRITE/DRAIN -> IDLE.
//  - cmd_ready=1 only in IDLE; accepted cmd latches addr, remaining count = cmd_len.
//  - WRITE: wdata_ready=1; per accepted beat, same cycle mem_mode=0, mem_addr=cur, mem_data_in=wdata;
//    cur increments, count decrements; no wdata_valid => mem_mode=1 (stall, no write). After last beat -> IDLE.
//  - READ: one address per cycle, mem_mode=1; rdata_valid/rdata exactly RD_LATENCY cycles later, in order.
//  - DRAIN: wait until in-flight reads retire, then IDLE; busy=1 in WRITE/READ/DRAIN.
//  - Address arithmetic mod 2**ADDR_W: addr 31 + 1 -> 0 (default, wrap).
//  - Back-to-back: next command accepted the cycle after return to IDLE (1 idle cycle min).
//  - rst mid-burst: aborts immediately, all outputs to reset values, in-flight read data discarded.
// CONFIGURATION
//  MEM_MASTER_BOUND_CHECK_EN defined: command with cmd_addr+cmd_len > 2**ADDR_W-1 is consumed
//   (cmd_ready handshake completes), not executed, err pulses 1 cycle, FSM stays IDLE.
//  Undefined: no check, err tied 0, bursts wrap around address 0.
// STRUCTURE
//  Package mem_master_pkg: state enum {IDLE,WRITE,READ,DRAIN}, MODE_WRITE=1'b0, MODE_READ=1'b1,
//   default ADDR_W/DATA_W constants.
//  Sub-module mem_rd_pipe: RD_LATENCY-deep valid shift register tagging read issues, async-reset.
// TESTING (bench instantiates single_port_memory as the target)
//  - Write len=0 addr=0 data 32'h01234567, read back addr=0 -> rdata=32'h01234567 after RD_LATENCY.
//  - Write burst addr=28 len=3 data 32'hA0..A3 -> locations 28..31; read burst returns A0..A3 in order.
//  - Write burst addr=30 len=3 (no bound check) -> 30,31,0,1 written; read 30 len=3 matches.
//  - Write with wdata_valid gapped every other cycle -> no spurious writes (mem_mode=1 on gaps), data intact.
//  - Assert rst during read burst at beat 2 -> rdata_valid=0 next cycle, busy=0, cmd_ready=1.
//  - BOUND_CHECK_EN: cmd addr=31 len=1 -> err pulse 1 cycle, memory unchanged, busy stays 0.

Source files
------------

// File: rtl/mem_master_pkg.sv
// Shared types and constants for the single-port memory initiator.
package mem_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_rd_pipe.sv
// Valid shift register that tags each read issue and marks when its data
// comes back from the memory RD_LATENCY cycles later.
module mem_rd_pipe #(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic rd_vld,
    output logic pending,
    output logic inflight
);

    localparam logic [RD_LATENCY-1:0] ONE  = 1;
    localparam logic [RD_LATENCY-1:0] TAIL = ONE << (RD_LATENCY - 1);

    logic [RD_LATENCY-1:0] vld_pipe;

    // Shift a tag in per issued read address; bit RD_LATENCY-1 lines up with mem_data_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= (vld_pipe << 1) | (issue ? ONE : '0);
    end

    assign rd_vld   = |(vld_pipe & TAIL);
    // Reads that will still be outstanding after the current cycle.
    assign pending  = |(vld_pipe & ~TAIL);
    assign inflight = |vld_pipe;

endmodule

// File: rtl/single_port_memory.sv
// 2**ADDR_W x DATA_W single-port memory, write when mode=0, read data
// appears RD_LATENCY cycles after the address is presented with mode=1.
module single_port_memory #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              mem_mode,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [DATA_W-1:0] mem_data_out
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_q [RD_LATENCY];

    // Array write port.
    always_ff @(posedge clk) begin
        if (!mem_mode) mem[mem_addr] <= mem_data_in;
    end

    // Read register plus extra latency stages.
    always_ff @(posedge clk) begin
        rd_q[0] <= mem[mem_addr];
        for (int i = 1; i < RD_LATENCY; i++) rd_q[i] <= rd_q[i-1];
    end

    assign mem_data_out = rd_q[RD_LATENCY-1];

endmodule

// File: rtl/single_port_mem_master.sv
// Initiator for the single-port memory: takes burst commands, sequences
// mem_mode/mem_addr/mem_data_in and streams read data back.
// Optional feature: MEM_MASTER_BOUND_CHECK_EN rejects bursts that would
// run past the top address (err pulse) instead of wrapping.
module single_port_mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] cnt;
    logic              rd_vld;
    logic              rd_pending;
    logic              rd_inflight;
    logic              bad_cmd;

`ifdef MEM_MASTER_BOUND_CHECK_EN
    logic [ADDR_W:0] end_addr;
    assign end_addr = {1'b0, cmd_addr} + {1'b0, cmd_len};
    assign bad_cmd  = end_addr[ADDR_W];
`else
    assign bad_cmd  = 1'b0;
`endif

    mem_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .issue    (state == READ),
        .rd_vld   (rd_vld),
        .pending  (rd_pending),
        .inflight (rd_inflight)
    );

    // Burst sequencing: latch command, walk address/count, wait out read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cur   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (bad_cmd) begin
                            err <= 1'b1;
                        end else begin
                            cur   <= cmd_addr;
                            cnt   <= cmd_len;
                            state <= cmd_write ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wdata_valid) begin
                        cur <= cur + 1'b1;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= IDLE;
                    end
                end
                READ: begin
                    cur <= cur + 1'b1;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= DRAIN;
                end
                DRAIN: begin
                    if (!rd_pending) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory drive: writes only on an accepted beat, otherwise a harmless read.
    always_comb begin
        mem_mode    = MODE_READ;
        mem_addr    = '0;
        mem_data_in = '0;
        if (state == WRITE && wdata_valid) begin
            mem_mode    = MODE_WRITE;
            mem_addr    = cur;
            mem_data_in = wdata;
        end else if (state == READ) begin
            mem_addr = cur;
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign wdata_ready = (state == WRITE);
    assign busy        = (state != IDLE) || rd_inflight;
    assign rdata_valid = rd_vld;
    assign rdata       = rd_vld ? mem_data_out : '0;

endmodule

// File: tb/tb_single_port_mem_master.sv
// Directed bench for single_port_mem_master driving single_port_memory,
// with a shadow memory and a read-data scoreboard queue.
module tb_single_port_mem_master;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid;
    logic [DW-1:0] rdata;
    logic          busy, err, mem_mode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_data_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] shadow [32];
    logic [DW-1:0] sb_q [$];

    always #5 clk = ~clk;

    single_port_mem_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata),
        .busy(busy), .err(err),
        .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    single_port_memory #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) u_mem (
        .clk(clk), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer a command at a falling edge, hold it across one rising edge.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                               input logic [DW-1:0] base, input bit gap);
        int i = 0;
        int cyc = 0;
        send_cmd(1'b1, a, l);
        while (i <= int'(l) && cyc < 200) begin
            if (gap && cyc[0]) begin
                wdata_valid = 1'b0;
                #1;
                chk("gap_mode_read", {31'd0, mem_mode}, 32'd1);
            end else begin
                logic [AW-1:0] ea;
                ea = a + AW'(i);
                wdata_valid = 1'b1;
                wdata = base + DW'(i);
                #1;
                chk("wr_mode", {31'd0, mem_mode}, 32'd0);
                chk("wr_addr", {27'd0, mem_addr}, {27'd0, ea});
                chk("wr_data", mem_data_in, base + DW'(i));
                shadow[ea] = base + DW'(i);
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        wdata_valid = 1'b0;
        chk("wr_done_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [AW-1:0] l);
        int k = 0;
        int beat = 0;
        for (int i = 0; i <= int'(l); i++) sb_q.push_back(shadow[a + AW'(i)]);
        send_cmd(1'b0, a, l);
        while (sb_q.size() > 0 && k < 100) begin
            if (rdata_valid) begin
                chk("rd_cycle", k, LAT + beat);
                chk("rd_data", rdata, sb_q.pop_front());
                beat++;
            end
            @(negedge clk);
            k++;
        end
        chk("rd_all_beats", sb_q.size(), 0);
        sb_q.delete();
        k = 0;
        while (busy && k < 50) begin @(negedge clk); k++; end
        chk("rd_busy_clear", {31'd0, busy}, 32'd0);
        chk("rd_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int k;
        int seen;
        for (int i = 0; i < 32; i++) shadow[i] = 'x;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_mode", {31'd0, mem_mode}, 32'd1);
        chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        chk("rst_mem_data_in", mem_data_in, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single beat write and read back.
        write_burst(5'd0, 5'd0, 32'h01234567, 1'b0);
        read_burst(5'd0, 5'd0);

        // Burst at the top of memory.
        write_burst(5'd28, 5'd3, 32'hA0, 1'b0);
        read_burst(5'd28, 5'd3);

`ifndef MEM_MASTER_BOUND_CHECK_EN
        // Burst wrapping past address 31.
        write_burst(5'd30, 5'd3, 32'hB0, 1'b0);
        read_burst(5'd30, 5'd3);
        read_burst(5'd0, 5'd1);
`endif

        // Gapped write data.
        write_burst(5'd8, 5'd4, 32'hC0DE0000, 1'b1);
        read_burst(5'd8, 5'd4);
        read_burst(5'd7, 5'd6);

        // Reset in the middle of a read burst.
        write_burst(5'd12, 5'd3, 32'hD0, 1'b0);
        send_cmd(1'b0, 5'd12, 5'd3);
        k = 0;
        while (!rdata_valid && k < 20) begin @(negedge clk); k++; end
        chk("rst_mid_first_beat", rdata, 32'hD0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_mid_mem_mode", {31'd0, mem_mode}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rdata_valid || busy) seen++;
        end
        chk("rst_mid_discard", seen, 0);
        read_burst(5'd13, 5'd1);

`ifdef MEM_MASTER_BOUND_CHECK_EN
        // Out-of-range command is swallowed with an err pulse.
        send_cmd(1'b1, 5'd31, 5'd1);
        #1;
        chk("bc_err_pulse", {31'd0, err}, 32'd1);
        chk("bc_busy", {31'd0, busy}, 32'd0);
        chk("bc_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        @(negedge clk);
        chk("bc_err_clear", {31'd0, err}, 32'd0);
        chk("bc_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        read_burst(5'd28, 5'd3);
        read_burst(5'd0, 5'd0);
`else
        chk("no_bc_err", {31'd0, err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
